// File: rtl/ising_pkg.sv
// ising_pkg: shared J-stream element type, streamer FSM states and column geometry helpers.
package ising_pkg;
    localparam int J_ELEMENT_WIDTH = 4;
    typedef logic [J_ELEMENT_WIDTH-1:0] j_elem_t;
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DONE} jstream_state_e;
    function automatic int epb(input int mem_w, input int elem_w);
        return mem_w / elem_w;
    endfunction
    function automatic int bpc(input int vec, input int mem_w, input int elem_w);
        return vec / epb(mem_w, elem_w);
    endfunction
endpackage

// File: rtl/j_col_buffer.sv
// j_col_buffer: one J column assembled beat by beat; full after the last beat, clear frees it.
module j_col_buffer #(
    parameter int VECTOR_SIZE     = 256,
    parameter int J_ELEMENT_WIDTH = 4,
    parameter int MEM_DATA_WIDTH  = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clr_i,
    input  logic                       wr_i,
    input  logic [MEM_DATA_WIDTH-1:0]  wdata_i,
    output logic                       full_o,
    output logic [J_ELEMENT_WIDTH-1:0] col_o [0:VECTOR_SIZE-1]
);
    import ising_pkg::*;
    localparam int EPB = epb(MEM_DATA_WIDTH, J_ELEMENT_WIDTH);
    localparam int BPC = bpc(VECTOR_SIZE, MEM_DATA_WIDTH, J_ELEMENT_WIDTH);
    localparam int BW  = (BPC > 1) ? $clog2(BPC) : 1;
    logic [BW-1:0]              r_beat;
    logic                       r_full;
    logic [J_ELEMENT_WIDTH-1:0] r_col [0:VECTOR_SIZE-1];
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_beat <= '0;
            r_full <= 1'b0;
            for (int i = 0; i < VECTOR_SIZE; i++) r_col[i] <= '0;
        end else if (clr_i) begin
            r_beat <= '0;
            r_full <= 1'b0;
        end else if (wr_i) begin
            for (int e = 0; e < EPB; e++)
                r_col[int'(r_beat) * EPB + e] <= wdata_i[e*J_ELEMENT_WIDTH +: J_ELEMENT_WIDTH];
            r_beat <= (r_beat == BW'(BPC - 1)) ? '0 : r_beat + 1'b1;
            if (r_beat == BW'(BPC - 1)) r_full <= 1'b1;
        end
    end
    assign full_o = r_full;
    assign col_o  = r_col;
endmodule

// File: rtl/j_column_streamer.sv
// j_column_streamer: fetches J columns beat by beat from memory and presents them on valid/ready.
// Define JSTREAM_DOUBLE_BUFFER_EN for ping-pong buffers (column n+1 fetched while n is presented).
module j_column_streamer #(
    parameter int VECTOR_SIZE     = 256,
    parameter int J_ELEMENT_WIDTH = 4,
    parameter int MEM_DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH      = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             start_i,
    input  logic [ADDR_WIDTH-1:0]            base_addr_i,
    input  logic [$clog2(VECTOR_SIZE):0]     num_cols_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             mem_req_o,
    output logic [ADDR_WIDTH-1:0]            mem_addr_o,
    input  logic                             mem_gnt_i,
    input  logic                             mem_rvalid_i,
    input  logic [MEM_DATA_WIDTH-1:0]        mem_rdata_i,
    output logic                             col_valid_o,
    input  logic                             col_ready_i,
    output logic [$clog2(VECTOR_SIZE)-1:0]   col_idx_o,
    output logic [J_ELEMENT_WIDTH-1:0]       J_col_o [0:VECTOR_SIZE-1]
);
    import ising_pkg::*;
    localparam int BPC = bpc(VECTOR_SIZE, MEM_DATA_WIDTH, J_ELEMENT_WIDTH);
    localparam int BW  = (BPC > 1) ? $clog2(BPC) : 1;
    localparam int IW  = $clog2(VECTOR_SIZE);
    jstream_state_e  r_state;
    logic            r_busy, r_done;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [IW:0]     r_ncols, r_fcol, r_ocol;
    logic [BW-1:0]   r_beat;
    logic            w_wr, w_last, w_hs, w_free, w_nfree, w_valid;
    assign w_wr   = (r_state == S_WAIT) && mem_rvalid_i;
    assign w_last = r_beat == BW'(BPC - 1);
    assign w_hs   = w_valid && col_ready_i;
`ifdef JSTREAM_DOUBLE_BUFFER_EN
    logic       r_wp, r_rp;
    logic [1:0] w_full;
    logic [J_ELEMENT_WIDTH-1:0] w_col0 [0:VECTOR_SIZE-1];
    logic [J_ELEMENT_WIDTH-1:0] w_col1 [0:VECTOR_SIZE-1];
    j_col_buffer #(.VECTOR_SIZE(VECTOR_SIZE), .J_ELEMENT_WIDTH(J_ELEMENT_WIDTH), .MEM_DATA_WIDTH(MEM_DATA_WIDTH)) u_buf0 (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(w_hs && !r_rp), .wr_i(w_wr && !r_wp),
        .wdata_i(mem_rdata_i), .full_o(w_full[0]), .col_o(w_col0));
    j_col_buffer #(.VECTOR_SIZE(VECTOR_SIZE), .J_ELEMENT_WIDTH(J_ELEMENT_WIDTH), .MEM_DATA_WIDTH(MEM_DATA_WIDTH)) u_buf1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(w_hs && r_rp), .wr_i(w_wr && r_wp),
        .wdata_i(mem_rdata_i), .full_o(w_full[1]), .col_o(w_col1));
    assign w_free  = !w_full[r_wp];
    assign w_nfree = !w_full[!r_wp];
    assign w_valid = w_full[r_rp];
    always_comb
        for (int i = 0; i < VECTOR_SIZE; i++) J_col_o[i] = r_rp ? w_col1[i] : w_col0[i];
    // write and read pointers each advance once per column, so columns leave in fetch order
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wp <= 1'b0;
            r_rp <= 1'b0;
        end else begin
            if (w_wr && w_last) r_wp <= !r_wp;
            if (w_hs) r_rp <= !r_rp;
        end
    end
`else
    logic w_full;
    j_col_buffer #(.VECTOR_SIZE(VECTOR_SIZE), .J_ELEMENT_WIDTH(J_ELEMENT_WIDTH), .MEM_DATA_WIDTH(MEM_DATA_WIDTH)) u_buf (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(w_hs), .wr_i(w_wr),
        .wdata_i(mem_rdata_i), .full_o(w_full), .col_o(J_col_o));
    assign w_free  = !w_full;
    assign w_nfree = 1'b0;
    assign w_valid = w_full;
`endif
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_addr  <= '0;
            r_ncols <= '0;
            r_fcol  <= '0;
            r_ocol  <= '0;
            r_beat  <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_hs) r_ocol <= r_ocol + 1'b1;
            case (r_state)
                S_IDLE: if (start_i) begin
                    r_busy  <= 1'b1;
                    r_addr  <= base_addr_i;
                    r_ncols <= num_cols_i;
                    r_fcol  <= '0;
                    r_ocol  <= '0;
                    r_beat  <= '0;
                    r_state <= (num_cols_i == '0) ? S_DONE : S_REQ;
                end
                S_REQ: if (mem_gnt_i) r_state <= S_WAIT;
                S_WAIT: if (mem_rvalid_i) begin
                    r_addr <= r_addr + 1'b1;
                    r_beat <= w_last ? '0 : r_beat + 1'b1;
                    if (w_last) r_fcol <= r_fcol + 1'b1;
                    r_state <= (!w_last || (r_fcol + 1'b1 != r_ncols && w_nfree)) ? S_REQ : S_HOLD;
                end
                // HOLD both waits for a free buffer and drains the final columns
                S_HOLD: if (r_fcol == r_ncols) begin
                    if (w_hs && r_ocol + 1'b1 == r_ncols) r_state <= S_DONE;
                end else if (w_free) r_state <= S_REQ;
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign mem_req_o   = r_state == S_REQ;
    assign mem_addr_o  = r_addr;
    assign col_valid_o = w_valid;
    assign col_idx_o   = r_ocol[IW-1:0];
endmodule
